// File: rtl/softmax_pkg.sv
// Shared types and fixed-point helpers for the softmax datapath arithmetic units.
package softmax_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } mult_state_t;

  // Working width of the rounding helper; callers must keep IN_WIDTH < FXP_MAX_W.
  localparam int FXP_MAX_W = 256;

  typedef struct packed {
    logic [FXP_MAX_W-1:0] value;
    logic                 sat;
  } fxp_rs_t;

  // Round half up, drop frac_bits, then clamp to out_width unsigned bits.
  function automatic fxp_rs_t fxp_round_sat_f(input logic [FXP_MAX_W-1:0] value,
                                              input int out_width,
                                              input int frac_bits);
    logic [FXP_MAX_W-1:0] half;
    logic [FXP_MAX_W-1:0] rounded;
    logic [FXP_MAX_W-1:0] limit;
    fxp_rs_t              res;
    half    = (frac_bits > 0) ? (FXP_MAX_W'(1) << (frac_bits - 1)) : '0;
    rounded = (value + half) >> frac_bits;
    limit   = (FXP_MAX_W'(1) << out_width) - FXP_MAX_W'(1);
    if (rounded > limit) begin
      res.value = limit;
      res.sat   = 1'b1;
    end else begin
      res.value = rounded;
      res.sat   = 1'b0;
    end
    return res;
  endfunction

endpackage

// File: rtl/fxp_round_sat.sv
// Combinational round-half-up and saturate of a wide unsigned fixed-point value.
module fxp_round_sat
  import softmax_pkg::*;
#(
  parameter int IN_WIDTH  = 64,
  parameter int OUT_WIDTH = 32,
  parameter int FRAC_BITS = 16
) (
  input  logic [IN_WIDTH-1:0]  product,
  output logic [OUT_WIDTH-1:0] result,
  output logic                 sat
);

  fxp_rs_t rs;
  logic    unused_hi;

  assign rs        = fxp_round_sat_f(FXP_MAX_W'(product), OUT_WIDTH, FRAC_BITS);
  assign result    = rs.value[OUT_WIDTH-1:0];
  assign sat       = rs.sat;
  assign unused_hi = ^rs.value[FXP_MAX_W-1:OUT_WIDTH];

endmodule

// File: rtl/seq_multiplier.sv
// Radix-2 shift-add unsigned multiplier: one adder, DATA_WIDTH iterations per product.
module seq_multiplier
  import softmax_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int FRAC_BITS  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [DATA_WIDTH-1:0]   multiplicand,
  input  logic [DATA_WIDTH-1:0]   multiplier,
  output logic [2*DATA_WIDTH-1:0] product,
  output logic [DATA_WIDTH-1:0]   result,
  output logic                    sat,
  output logic                    busy,
  output logic                    done
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);

  mult_state_t           state;
  logic [DATA_WIDTH-1:0] mcand_reg;
  logic [DATA_WIDTH:0]   mplr_reg;
  logic [DATA_WIDTH:0]   acc;
  logic [CNT_W-1:0]      count;

  logic [DATA_WIDTH:0]   sum;
  logic [2*DATA_WIDTH:0] shifted;
  logic [DATA_WIDTH:0]   acc_next;
  logic [DATA_WIDTH:0]   mplr_next;
  logic                  unused_mplr_msb;

  // The acc/mplr pair acts as one shift register: the low sum bit moves into
  // the multiplier half as its consumed LSB drops out.
  always_comb begin
    sum       = acc + (mplr_reg[0] ? {1'b0, mcand_reg} : '0);
    shifted   = {sum, mplr_reg[DATA_WIDTH-1:0]} >> 1;
    acc_next  = shifted[2*DATA_WIDTH:DATA_WIDTH];
    mplr_next = {1'b0, shifted[DATA_WIDTH-1:0]};
  end

  assign unused_mplr_msb = mplr_reg[DATA_WIDTH];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      mcand_reg <= '0;
      mplr_reg  <= '0;
      acc       <= '0;
      count     <= '0;
      product   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mcand_reg <= multiplicand;
            mplr_reg  <= {1'b0, multiplier};
            acc       <= '0;
            count     <= CNT_W'(DATA_WIDTH);
            state     <= CALC;
          end
        end
        CALC: begin
          acc      <= acc_next;
          mplr_reg <= mplr_next;
          count    <= count - CNT_W'(1);
          if (count == CNT_W'(1)) begin
            product <= {acc_next[DATA_WIDTH-1:0], mplr_next[DATA_WIDTH-1:0]};
            state   <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  fxp_round_sat #(
    .IN_WIDTH (2 * DATA_WIDTH),
    .OUT_WIDTH(DATA_WIDTH),
    .FRAC_BITS(FRAC_BITS)
  ) u_round_sat (
    .product(product),
    .result (result),
    .sat    (sat)
  );

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed bench for seq_multiplier: 16-bit operands, Q8 and Q16 result ports.
module tb_seq_multiplier;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] a_in;
  logic [15:0] b_in;

  logic [31:0] product,  product_f16;
  logic [15:0] result,   result_f16;
  logic        sat,      sat_f16;
  logic        busy,     busy_f16;
  logic        done,     done_f16;

  int passes = 0;
  int total  = 0;

  seq_multiplier #(.DATA_WIDTH(16), .FRAC_BITS(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .multiplicand(a_in), .multiplier(b_in),
    .product(product), .result(result), .sat(sat), .busy(busy), .done(done)
  );

  seq_multiplier #(.DATA_WIDTH(16), .FRAC_BITS(16)) dut_f16 (
    .clk(clk), .rst_n(rst_n), .start(start),
    .multiplicand(a_in), .multiplier(b_in),
    .product(product_f16), .result(result_f16), .sat(sat_f16), .busy(busy_f16),
    .done(done_f16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    total++;
    assert (observed === expected) passes++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch one operation and wait (bounded) for done; lat counts edges from the accepting edge.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                        output int lat, output int busy_n);
    tick();
    start = 1'b1;
    a_in  = a;
    b_in  = b;
    tick();
    start  = 1'b0;
    a_in   = 16'hDEAD;
    b_in   = 16'hBEEF;
    lat    = 0;
    busy_n = 0;
    for (int n = 1; n <= 40; n++) begin
      if (busy) busy_n++;
      if (done) begin
        lat = n;
        break;
      end
      tick();
    end
  endtask

  initial begin
    int lat, busy_n, ndone, first, k, last;
    logic [15:0] pa [3];
    logic [15:0] pb [3];
    logic [31:0] pe [3];

    rst_n = 1'b0;
    start = 1'b0;
    a_in  = '0;
    b_in  = '0;
    repeat (3) tick();
    check("reset_done",    64'(done),    64'h0);
    check("reset_busy",    64'(busy),    64'h0);
    check("reset_product", 64'(product), 64'h0);
    check("reset_result",  64'(result),  64'h0);
    check("reset_sat",     64'(sat),     64'h0);
    rst_n = 1'b1;

    // 3 * 5: latency and busy window
    run_op(16'd3, 16'd5, lat, busy_n);
    check("op3x5_latency",    64'(lat),     64'd17);
    check("op3x5_busy_len",   64'(busy_n),  64'd17);
    check("op3x5_product",    64'(product), 64'h0000000F);
    check("op3x5_result",     64'(result),  64'h0000);
    check("op3x5_sat",        64'(sat),     64'h0);
    check("op3x5_result_q16", 64'(result_f16), 64'h0000);
    tick();
    check("op3x5_done_width", 64'(done), 64'h0);
    check("op3x5_busy_fall",  64'(busy), 64'h0);

    // 1.0 * 1.5 in Q8
    run_op(16'h0100, 16'h0180, lat, busy_n);
    check("q8_1x1p5_product", 64'(product), 64'h00018000);
    check("q8_1x1p5_result",  64'(result),  64'h0180);
    check("q8_1x1p5_sat",     64'(sat),     64'h0);

    // Rounding boundary: exactly one half rounds up, just below rounds down
    run_op(16'h0001, 16'h0080, lat, busy_n);
    check("round_half_product", 64'(product), 64'h00000080);
    check("round_half_result",  64'(result),  64'h0001);
    run_op(16'h0001, 16'h007F, lat, busy_n);
    check("round_below_product", 64'(product), 64'h0000007F);
    check("round_below_result",  64'(result),  64'h0000);

    // Largest operands: saturates in Q8, fits in Q16
    run_op(16'hFFFF, 16'hFFFF, lat, busy_n);
    check("max_product",     64'(product),     64'hFFFE0001);
    check("max_result",      64'(result),      64'hFFFF);
    check("max_sat",         64'(sat),         64'h1);
    check("max_product_q16", 64'(product_f16), 64'hFFFE0001);
    check("max_result_q16",  64'(result_f16),  64'hFFFE);
    check("max_sat_q16",     64'(sat_f16),     64'h0);
    tick();

    // start pulsed during CALC must be ignored
    tick();
    start = 1'b1;
    a_in  = 16'd7;
    b_in  = 16'd9;
    tick();
    start = 1'b0;
    ndone = 0;
    first = 0;
    for (int n = 1; n <= 30; n++) begin
      if (n == 5) begin
        start = 1'b1;
        a_in  = 16'd2;
        b_in  = 16'd2;
      end else if (n == 6) begin
        start = 1'b0;
      end
      if (done) begin
        ndone++;
        if (first == 0) first = n;
      end
      tick();
    end
    check("ignore_done_count", 64'(ndone),   64'd1);
    check("ignore_done_cycle", 64'(first),   64'd17);
    check("ignore_product",    64'(product), 64'd63);

    // start held high: back-to-back operations every 18 cycles
    pa[0] = 16'd10;     pb[0] = 16'd11;   pe[0] = 32'd110;
    pa[1] = 16'd300;    pb[1] = 16'd200;  pe[1] = 32'h0000EA60;
    pa[2] = 16'h1234;   pb[2] = 16'h0010; pe[2] = 32'h00012340;
    a_in  = pa[0];
    b_in  = pb[0];
    start = 1'b1;
    k     = 0;
    last  = 0;
    for (int n = 1; n <= 80; n++) begin
      tick();
      if (done) begin
        check($sformatf("held_product_%0d", k), 64'(product), 64'(pe[k]));
        if (k > 0) check($sformatf("held_period_%0d", k), 64'(n - last), 64'd18);
        last = n;
        k++;
        if (k < 3) begin
          a_in = pa[k];
          b_in = pb[k];
        end else begin
          start = 1'b0;
          break;
        end
      end
    end
    check("held_done_count", 64'(k), 64'd3);
    tick();

    // Reset mid-operation aborts without a done pulse and clears product
    tick();
    start = 1'b1;
    a_in  = 16'hFFFF;
    b_in  = 16'd2;
    tick();
    start = 1'b0;
    ndone = 0;
    for (int n = 1; n < 8; n++) begin
      if (done) ndone++;
      tick();
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("abort_busy",    64'(busy),    64'h0);
    check("abort_done",    64'(done),    64'h0);
    check("abort_product", 64'(product), 64'h0);
    check("abort_result",  64'(result),  64'h0);
    for (int n = 0; n < 20; n++) begin
      if (done) ndone++;
      tick();
    end
    check("abort_no_done", 64'(ndone), 64'd0);

    run_op(16'd4, 16'd4, lat, busy_n);
    check("post_abort_latency", 64'(lat),     64'd17);
    check("post_abort_product", 64'(product), 64'd16);
    tick();

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
